// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants for the two-requester stack arbiter
package stack_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  // On a tie the requester that was not granted last wins; last resets to REQ1.
  function automatic req_id_e tie_winner(input req_id_e last);
    return (last == REQ1) ? REQ0 : REQ1;
  endfunction

endpackage

// File: rtl/stack_arbiter_if.sv
// rtl/stack_arbiter_if.sv - request/response bundle between stack users and the arbiter
interface stack_arbiter_if import stack_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             req0_valid;
  logic             req0_op;
  logic [WIDTH-1:0] req0_wdata;
  logic             req0_ready;

  logic             req1_valid;
  logic             req1_op;
  logic [WIDTH-1:0] req1_wdata;
  logic             req1_ready;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [CW-1:0]    count;

  modport master (
    output req0_valid, req0_op, req0_wdata,
    output req1_valid, req1_op, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, count
  );

  modport slave (
    input  req0_valid, req0_op, req0_wdata,
    input  req1_valid, req1_op, req1_wdata,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err, count
  );

endinterface

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - DEPTH x WIDTH register array, one write port, one async read port
module stack_mem import stack_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - round-robin arbiter in front of a shared LIFO with tagged responses
module stack_arbiter import stack_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  stack_arbiter_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             last_q, last_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant0, grant1, hs;
  logic             sel_op;
  logic [WIDTH-1:0] sel_wdata;
  logic             full, empty, do_push, do_pop;
  logic [CW-1:0]    count_m1;
  logic [WIDTH-1:0] rd_data;
  req_id_e          tie_pick;

  assign tie_pick = tie_winner(req_id_e'(last_q));

  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = (tie_pick == REQ0);
        grant1 = (tie_pick == REQ1);
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
    hs        = grant0 | grant1;
    sel_op    = grant1 ? bus.req1_op    : bus.req0_op;
    sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
  end

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count_m1 = count_q - CW'(1);
  assign do_push  = hs && (sel_op == OP_PUSH) && !full;
  assign do_pop   = hs && (sel_op == OP_POP)  && !empty;

  // Pop data is read combinationally from the pre-update top entry.
  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (do_push),
    .wr_addr_i (count_q[AW-1:0]),
    .wr_data_i (sel_wdata),
    .rd_addr_i (count_m1[AW-1:0]),
    .rd_data_o (rd_data)
  );

  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    if (do_push) begin
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      count_d = count_m1;
    end
    if (hs) begin
      last_d = grant1;
    end
    rsp_valid_d = hs;
    rsp_id_d    = grant1;
    rsp_data_d  = do_pop ? rd_data : '0;
    rsp_err_d   = hs && !(do_push || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.count      = count_q;

endmodule
